idex_stage: RTL and testbench
=============================

Name: idex_stage

Overview:
- Decode-side consumer of the register file's read ports.
- Selects forwarded operands from EX, MEM or the register file, detects load-use hazards, and generates the stall signal.
- Latches decoded control and operands into the ID/EX pipeline register on the rising clock edge.
- Its outputs feed the EX stage directly. WB-stage forwarding is not required: the register file writes on the falling edge, so a WB result is readable in the same cycle.

Parameters:
- DW, 32, data width of operands, immediate and forwarded results.
- RW, 5, register-number width.

Ports:
- clk  in  1  pipeline clock; register updates on posedge
- clrn  in  1  reset, asynchronous, active-low
- rna  in  RW  source register rs (regfile read port A address)
- rnb  in  RW  source register rt (regfile read port B address)
- qa  in  DW  regfile read data A
- qb  in  DW  regfile read data B
- use_rs  in  1  instruction reads rs
- use_rt  in  1  instruction reads rt
- id_wreg  in  1  decoded: writes register
- id_m2reg  in  1  decoded: is load
- id_wmem  in  1  decoded: is store
- id_aluc  in  4  decoded ALU control
- id_aluimm  in  1  decoded: ALU B from immediate
- id_imm  in  DW  extended immediate
- id_rn  in  RW  destination register number
- flush  in  1  taken branch/jump; squash the instruction in ID
- ex_wreg  in  1  EX stage: writes register
- ex_m2reg  in  1  EX stage: is load
- ex_rn  in  RW  EX stage destination
- ex_alu  in  DW  EX stage ALU result
- mm_wreg  in  1  MEM stage: writes register
- mm_m2reg  in  1  MEM stage: is load
- mm_rn  in  RW  MEM stage destination
- mm_alu  in  DW  MEM stage ALU result
- mm_mdo  in  DW  MEM stage load data
- fwda  out  2  A source: 0 regfile, 1 EX alu, 2 MEM alu, 3 MEM mdo
- fwdb  out  2  B source, same encoding as fwda
- stall  out  1  load-use hazard; PC and IF/ID hold when high
- e_wreg, e_m2reg, e_wmem, e_aluimm  out  1 each  registered controls
- e_aluc  out  4  registered ALU control
- e_a  out  DW  registered operand A
- e_b  out  DW  registered operand B
- e_imm  out  DW  registered immediate
- e_rn  out  RW  registered destination

Behaviour:
- Forwarding (combinational, per operand X ∈ {A: rna/qa, B: rnb/qb}), priority EX > MEM > regfile:
  - EX hit: ex_wreg & ~ex_m2reg & ex_rn!=0 & ex_rn==rnX -> code 1 (ex_alu).
  - Otherwise MEM hit: mm_wreg & mm_rn!=0 & mm_rn==rnX -> code 3 (mm_mdo) if mm_m2reg, else code 2 (mm_alu).
  - Otherwise code 0 (qX).
  - Register 0 never forwards; the operand is qX, which is 0.
- stall = ex_wreg & ex_m2reg & ex_rn!=0 & ((use_rs & ex_rn==rna) | (use_rt & ex_rn==rnb)). Purely combinational, no latency.
- A stall is not masked by flush. stall and flush high together: bubble inserted, stall still asserted.
- ID/EX register, posedge clk:
  - Normal: all e_* load their id_* counterparts. e_a/e_b load the forwarded values.
  - Bubble (stall | flush): e_wreg, e_m2reg, e_wmem forced to 0. e_aluc, e_aluimm, e_a, e_b, e_imm, e_rn load normally, which is harmless.
  - No hold mode: ID/EX loads every cycle. On a stall the instruction remains in ID and re-issues next cycle with a fresh forwarding decision, now from MEM code 3.
- Reset (clrn=0, asynchronous): every e_* output is 0 immediately and held while low. The first posedge after release loads normally.
  - Reset mid-instruction discards the ID/EX contents.
- fwda, fwdb and stall have no reset value; they depend only on inputs.
- Width: all compares are exact RW-bit; the block performs no arithmetic.

Test Plan:
- Reset: clrn=0 with id_wreg=1, id_imm=32'h1234 -> all e_* = 0 asynchronously. After release, the next posedge gives e_wreg=1, e_imm=32'h1234.
- EX forward priority: rna=5, ex_wreg=1, ex_m2reg=0, ex_rn=5, ex_alu=32'hAAAA, mm_wreg=1, mm_rn=5, mm_alu=32'hBBBB -> fwda=1; e_a=32'hAAAA after posedge.
- MEM load forward: rnb=7, EX no hit, mm_wreg=1, mm_m2reg=1, mm_rn=7, mm_mdo=32'hCAFE -> fwdb=3, e_b=32'hCAFE.
- Register 0: rna=0, ex_wreg=1, ex_rn=0, ex_alu=32'hFFFF, qa=0 -> fwda=0, e_a=0, stall=0 even when ex_m2reg=1.
- Load-use: ex_wreg=1, ex_m2reg=1, ex_rn=3, rnb=3, use_rt=1, id_wreg=1 -> stall=1, e_wreg=0 after posedge. With use_rt=0 -> stall=0, e_wreg=1.
- Flush: flush=1, id_wmem=1, id_wreg=1 -> e_wmem=0, e_wreg=0, stall unaffected. Next cycle with flush=0 -> normal load.

Source files
------------

// File: rtl/idex_stage_if.sv
// ID/EX stage bus: regfile read data, decoded controls, EX/MEM
// forwarding sources in; forwarding selects, stall and ID/EX register out.
interface idex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic [RW-1:0] rna;
  logic [RW-1:0] rnb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic          use_rs;
  logic          use_rt;
  logic          id_wreg;
  logic          id_m2reg;
  logic          id_wmem;
  logic [3:0]    id_aluc;
  logic          id_aluimm;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rn;
  logic          flush;
  logic          ex_wreg;
  logic          ex_m2reg;
  logic [RW-1:0] ex_rn;
  logic [DW-1:0] ex_alu;
  logic          mm_wreg;
  logic          mm_m2reg;
  logic [RW-1:0] mm_rn;
  logic [DW-1:0] mm_alu;
  logic [DW-1:0] mm_mdo;
  logic [1:0]    fwda;
  logic [1:0]    fwdb;
  logic          stall;
  logic          e_wreg;
  logic          e_m2reg;
  logic          e_wmem;
  logic          e_aluimm;
  logic [3:0]    e_aluc;
  logic [DW-1:0] e_a;
  logic [DW-1:0] e_b;
  logic [DW-1:0] e_imm;
  logic [RW-1:0] e_rn;

  modport master (
    output rna, rnb, qa, qb, use_rs, use_rt,
    output id_wreg, id_m2reg, id_wmem, id_aluc,
    output id_aluimm, id_imm, id_rn, flush,
    output ex_wreg, ex_m2reg, ex_rn, ex_alu,
    output mm_wreg, mm_m2reg, mm_rn, mm_alu, mm_mdo,
    input  fwda, fwdb, stall,
    input  e_wreg, e_m2reg, e_wmem, e_aluimm,
    input  e_aluc, e_a, e_b, e_imm, e_rn
  );

  modport slave (
    input  rna, rnb, qa, qb, use_rs, use_rt,
    input  id_wreg, id_m2reg, id_wmem, id_aluc,
    input  id_aluimm, id_imm, id_rn, flush,
    input  ex_wreg, ex_m2reg, ex_rn, ex_alu,
    input  mm_wreg, mm_m2reg, mm_rn, mm_alu, mm_mdo,
    output fwda, fwdb, stall,
    output e_wreg, e_m2reg, e_wmem, e_aluimm,
    output e_aluc, e_a, e_b, e_imm, e_rn
  );
endinterface

// File: rtl/idex_stage.sv
// Decode-side operand forwarding, load-use stall detection
// and the ID/EX pipeline register.
module idex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic         clk,
  input logic         clrn,
  idex_stage_if.slave bus
);
  logic          w_exa, w_exb;
  logic          w_mma, w_mmb;
  logic          w_ldx;
  logic          w_stall;
  logic          w_bub;
  logic [1:0]    w_fwda, w_fwdb;
  logic [DW-1:0] w_a, w_b;

  logic          r_wreg, r_m2reg, r_wmem, r_aluimm;
  logic [3:0]    r_aluc;
  logic [DW-1:0] r_a, r_b, r_imm;
  logic [RW-1:0] r_rn;

  // EX loads cannot forward; their data arrives one stage later
  assign w_exa = bus.ex_wreg & ~bus.ex_m2reg & (|bus.ex_rn)
               & (bus.ex_rn == bus.rna);
  assign w_exb = bus.ex_wreg & ~bus.ex_m2reg & (|bus.ex_rn)
               & (bus.ex_rn == bus.rnb);
  assign w_mma = ~w_exa & bus.mm_wreg & (|bus.mm_rn)
               & (bus.mm_rn == bus.rna);
  assign w_mmb = ~w_exb & bus.mm_wreg & (|bus.mm_rn)
               & (bus.mm_rn == bus.rnb);

  assign w_ldx   = bus.ex_wreg & bus.ex_m2reg & (|bus.ex_rn);
  assign w_stall = w_ldx
                 & ((bus.use_rs & (bus.ex_rn == bus.rna))
                  | (bus.use_rt & (bus.ex_rn == bus.rnb)));
  assign w_bub   = w_stall | bus.flush;

  always_comb begin
    w_fwda = 2'd0;
    unique case (1'b1)
      w_exa:                  w_fwda = 2'd1;
      w_mma & ~bus.mm_m2reg:  w_fwda = 2'd2;
      w_mma &  bus.mm_m2reg:  w_fwda = 2'd3;
      default:                w_fwda = 2'd0;
    endcase
  end

  always_comb begin
    w_fwdb = 2'd0;
    unique case (1'b1)
      w_exb:                  w_fwdb = 2'd1;
      w_mmb & ~bus.mm_m2reg:  w_fwdb = 2'd2;
      w_mmb &  bus.mm_m2reg:  w_fwdb = 2'd3;
      default:                w_fwdb = 2'd0;
    endcase
  end

  always_comb begin
    w_a = bus.qa;
    case (w_fwda)
      2'd1:    w_a = bus.ex_alu;
      2'd2:    w_a = bus.mm_alu;
      2'd3:    w_a = bus.mm_mdo;
      default: w_a = bus.qa;
    endcase
  end

  always_comb begin
    w_b = bus.qb;
    case (w_fwdb)
      2'd1:    w_b = bus.ex_alu;
      2'd2:    w_b = bus.mm_alu;
      2'd3:    w_b = bus.mm_mdo;
      default: w_b = bus.qb;
    endcase
  end

  // Loads every cycle; a bubble only clears the state-changing controls
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
      r_aluimm <= 1'b0;
      r_aluc   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_rn     <= '0;
    end else begin
      r_wreg   <= bus.id_wreg  & ~w_bub;
      r_m2reg  <= bus.id_m2reg & ~w_bub;
      r_wmem   <= bus.id_wmem  & ~w_bub;
      r_aluimm <= bus.id_aluimm;
      r_aluc   <= bus.id_aluc;
      r_a      <= w_a;
      r_b      <= w_b;
      r_imm    <= bus.id_imm;
      r_rn     <= bus.id_rn;
    end
  end

  assign bus.fwda     = w_fwda;
  assign bus.fwdb     = w_fwdb;
  assign bus.stall    = w_stall;
  assign bus.e_wreg   = r_wreg;
  assign bus.e_m2reg  = r_m2reg;
  assign bus.e_wmem   = r_wmem;
  assign bus.e_aluimm = r_aluimm;
  assign bus.e_aluc   = r_aluc;
  assign bus.e_a      = r_a;
  assign bus.e_b      = r_b;
  assign bus.e_imm    = r_imm;
  assign bus.e_rn     = r_rn;
endmodule

// File: tb/tb_idex_stage.sv
// Testbench for idex_stage: directed vector table, hand sequences
// for reset and load-use re-issue, and a random run against a model.
module tb_idex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  idex_stage_if #(.DW(DW), .RW(RW)) bus ();

  idex_stage #(.DW(DW), .RW(RW)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rna, rnb;
    logic [DW-1:0] qa, qb;
    logic          use_rs, use_rt;
    logic          id_wreg, id_wmem, flush;
    logic          ex_wreg, ex_m2reg;
    logic [RW-1:0] ex_rn;
    logic [DW-1:0] ex_alu;
    logic          mm_wreg, mm_m2reg;
    logic [RW-1:0] mm_rn;
    logic [DW-1:0] mm_alu, mm_mdo;
    logic [1:0]    x_fwda, x_fwdb;
    logic          x_stall;
    logic [DW-1:0] x_ea, x_eb;
    logic          x_wreg, x_wmem;
  } vec_t;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.rna = '0; bus.rnb = '0; bus.qa = '0; bus.qb = '0;
    bus.use_rs = 0; bus.use_rt = 0;
    bus.id_wreg = 0; bus.id_m2reg = 0; bus.id_wmem = 0;
    bus.id_aluc = '0; bus.id_aluimm = 0; bus.id_imm = '0;
    bus.id_rn = '0; bus.flush = 0;
    bus.ex_wreg = 0; bus.ex_m2reg = 0; bus.ex_rn = '0;
    bus.ex_alu = '0;
    bus.mm_wreg = 0; bus.mm_m2reg = 0; bus.mm_rn = '0;
    bus.mm_alu = '0; bus.mm_mdo = '0;
  endtask

  task automatic drive(vec_t v);
    idle();
    bus.rna = v.rna; bus.rnb = v.rnb;
    bus.qa = v.qa; bus.qb = v.qb;
    bus.use_rs = v.use_rs; bus.use_rt = v.use_rt;
    bus.id_wreg = v.id_wreg; bus.id_wmem = v.id_wmem;
    bus.flush = v.flush;
    bus.ex_wreg = v.ex_wreg; bus.ex_m2reg = v.ex_m2reg;
    bus.ex_rn = v.ex_rn; bus.ex_alu = v.ex_alu;
    bus.mm_wreg = v.mm_wreg; bus.mm_m2reg = v.mm_m2reg;
    bus.mm_rn = v.mm_rn; bus.mm_alu = v.mm_alu;
    bus.mm_mdo = v.mm_mdo;
  endtask

  // Reference: walk the producers from youngest to oldest and take
  // the first one whose result is already available for register rn.
  function automatic logic [1:0] m_src(logic [RW-1:0] rn);
    logic [RW-1:0] dst [2];
    logic          ok  [2];
    logic [1:0]    code[2];
    dst[0] = bus.ex_rn; dst[1] = bus.mm_rn;
    ok[0] = bus.ex_wreg && !bus.ex_m2reg;
    ok[1] = bus.mm_wreg;
    code[0] = 2'd1;
    code[1] = bus.mm_m2reg ? 2'd3 : 2'd2;
    if (rn == 0) return 2'd0;
    for (int s = 0; s < 2; s++)
      if (ok[s] && dst[s] == rn) return code[s];
    return 2'd0;
  endfunction

  function automatic logic [DW-1:0] m_val(logic [1:0] c, logic [DW-1:0] q);
    logic [DW-1:0] src [4];
    src[0] = q; src[1] = bus.ex_alu;
    src[2] = bus.mm_alu; src[3] = bus.mm_mdo;
    return src[c];
  endfunction

  function automatic logic m_stall();
    logic hz_a, hz_b;
    if (!(bus.ex_wreg && bus.ex_m2reg) || bus.ex_rn == 0) return 1'b0;
    hz_a = bus.use_rs && bus.ex_rn == bus.rna;
    hz_b = bus.use_rt && bus.ex_rn == bus.rnb;
    return hz_a || hz_b;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [1:0]    xa, xb;
    logic          xs, bub;
    logic [DW-1:0] ea, eb, ximm;
    logic          xw, xm, xs_m, xai;
    logic [3:0]    xal;
    logic [RW-1:0] xrn;

    idle();
    bus.id_wreg = 1; bus.id_imm = 32'h1234;

    // Reset: outputs zero while clrn low, then first posedge loads
    #2;
    chk("rst_e_wreg", {31'b0, bus.e_wreg}, 0);
    chk("rst_e_imm", bus.e_imm, 0);
    @(posedge clk); #1;
    chk("rst_hold_e_wreg", {31'b0, bus.e_wreg}, 0);
    @(negedge clk); clrn = 1;
    @(posedge clk); #1;
    chk("rel_e_wreg", {31'b0, bus.e_wreg}, 1);
    chk("rel_e_imm", bus.e_imm, 32'h1234);
    // Async reset mid-cycle discards contents
    #2 clrn = 0; #1;
    chk("async_e_wreg", {31'b0, bus.e_wreg}, 0);
    chk("async_e_imm", bus.e_imm, 0);
    @(negedge clk); clrn = 1;

    tbl.push_back('{rna:5, qa:1, rnb:9, qb:32'h2222, id_wreg:1,
      ex_wreg:1, ex_rn:5, ex_alu:32'hAAAA,
      mm_wreg:1, mm_rn:5, mm_alu:32'hBBBB,
      x_fwda:1, x_fwdb:0, x_stall:0, x_ea:32'hAAAA, x_eb:32'h2222,
      x_wreg:1, x_wmem:0, default:0});
    tbl.push_back('{rna:1, qa:32'h1111, rnb:7, id_wreg:1,
      ex_wreg:1, ex_rn:4, ex_alu:32'h4444,
      mm_wreg:1, mm_m2reg:1, mm_rn:7, mm_mdo:32'hCAFE,
      x_fwda:0, x_fwdb:3, x_stall:0, x_ea:32'h1111, x_eb:32'hCAFE,
      x_wreg:1, x_wmem:0, default:0});
    tbl.push_back('{rna:6, qa:32'h6, rnb:6, qb:32'h6, id_wreg:1,
      mm_wreg:1, mm_rn:6, mm_alu:32'hBBBB, mm_mdo:32'hDDDD,
      x_fwda:2, x_fwdb:2, x_stall:0, x_ea:32'hBBBB, x_eb:32'hBBBB,
      x_wreg:1, x_wmem:0, default:0});
    tbl.push_back('{rna:0, qa:0, use_rs:1, id_wreg:1,
      ex_wreg:1, ex_m2reg:1, ex_rn:0, ex_alu:32'hFFFF,
      mm_wreg:1, mm_rn:0, mm_alu:32'hEEEE,
      x_fwda:0, x_fwdb:0, x_stall:0, x_ea:0, x_eb:0,
      x_wreg:1, x_wmem:0, default:0});
    tbl.push_back('{rna:0, qa:0, id_wreg:1,
      ex_wreg:1, ex_m2reg:0, ex_rn:0, ex_alu:32'hFFFF,
      x_fwda:0, x_fwdb:0, x_stall:0, x_ea:0, x_eb:0,
      x_wreg:1, x_wmem:0, default:0});
    tbl.push_back('{rnb:3, qb:32'h3333, use_rt:1, id_wreg:1,
      ex_wreg:1, ex_m2reg:1, ex_rn:3, ex_alu:32'h9999,
      x_fwda:0, x_fwdb:0, x_stall:1, x_ea:0, x_eb:32'h3333,
      x_wreg:0, x_wmem:0, default:0});
    tbl.push_back('{rnb:3, qb:32'h3333, use_rt:0, id_wreg:1,
      ex_wreg:1, ex_m2reg:1, ex_rn:3, ex_alu:32'h9999,
      x_fwda:0, x_fwdb:0, x_stall:0, x_ea:0, x_eb:32'h3333,
      x_wreg:1, x_wmem:0, default:0});
    tbl.push_back('{rna:8, qa:32'h8, use_rs:1, id_wmem:1,
      ex_wreg:1, ex_m2reg:1, ex_rn:8,
      x_fwda:0, x_fwdb:0, x_stall:1, x_ea:32'h8, x_eb:0,
      x_wreg:0, x_wmem:0, default:0});
    tbl.push_back('{rna:2, qa:32'h22, flush:1, id_wreg:1, id_wmem:1,
      x_fwda:0, x_fwdb:0, x_stall:0, x_ea:32'h22, x_eb:0,
      x_wreg:0, x_wmem:0, default:0});
    tbl.push_back('{rnb:4, qb:32'h44, use_rt:1, flush:1, id_wreg:1,
      ex_wreg:1, ex_m2reg:1, ex_rn:4,
      x_fwda:0, x_fwdb:0, x_stall:1, x_ea:0, x_eb:32'h44,
      x_wreg:0, x_wmem:0, default:0});
    tbl.push_back('{rna:2, qa:32'h22, id_wreg:1, id_wmem:1,
      x_fwda:0, x_fwdb:0, x_stall:0, x_ea:32'h22, x_eb:0,
      x_wreg:1, x_wmem:1, default:0});
    tbl.push_back('{rna:9, qa:32'h9, id_wreg:1,
      ex_wreg:0, ex_rn:9, ex_alu:32'h1,
      mm_wreg:1, mm_rn:9, mm_alu:32'h2,
      x_fwda:2, x_fwdb:0, x_stall:0, x_ea:32'h2, x_eb:0,
      x_wreg:1, x_wmem:0, default:0});

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_fwda", i), {30'b0, bus.fwda}, {30'b0, tbl[i].x_fwda});
      chk($sformatf("v%0d_fwdb", i), {30'b0, bus.fwdb}, {30'b0, tbl[i].x_fwdb});
      chk($sformatf("v%0d_stall", i), {31'b0, bus.stall}, {31'b0, tbl[i].x_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d_e_a", i), bus.e_a, tbl[i].x_ea);
      chk($sformatf("v%0d_e_b", i), bus.e_b, tbl[i].x_eb);
      chk($sformatf("v%0d_e_wreg", i), {31'b0, bus.e_wreg}, {31'b0, tbl[i].x_wreg});
      chk($sformatf("v%0d_e_wmem", i), {31'b0, bus.e_wmem}, {31'b0, tbl[i].x_wmem});
    end

    // Load-use: stall, then the load moves to MEM and re-issue forwards mdo
    @(negedge clk);
    idle();
    bus.rnb = 3; bus.qb = 32'h0BAD; bus.use_rt = 1; bus.id_wreg = 1;
    bus.ex_wreg = 1; bus.ex_m2reg = 1; bus.ex_rn = 3;
    #1;
    chk("lu_stall", {31'b0, bus.stall}, 1);
    @(posedge clk); #1;
    chk("lu_bubble_wreg", {31'b0, bus.e_wreg}, 0);
    @(negedge clk);
    bus.ex_wreg = 0; bus.ex_m2reg = 0; bus.ex_rn = 0;
    bus.mm_wreg = 1; bus.mm_m2reg = 1; bus.mm_rn = 3;
    bus.mm_mdo = 32'h5EED;
    #1;
    chk("lu_re_stall", {31'b0, bus.stall}, 0);
    chk("lu_re_fwdb", {30'b0, bus.fwdb}, 3);
    @(posedge clk); #1;
    chk("lu_re_e_b", bus.e_b, 32'h5EED);
    chk("lu_re_e_wreg", {31'b0, bus.e_wreg}, 1);

    // Random run against the reference model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.rna = RW'($urandom_range(0, 3));
      bus.rnb = RW'($urandom_range(0, 3));
      bus.qa = (bus.rna == 0) ? '0 : $urandom;
      bus.qb = (bus.rnb == 0) ? '0 : $urandom;
      bus.use_rs = 1'($urandom); bus.use_rt = 1'($urandom);
      bus.id_wreg = 1'($urandom); bus.id_m2reg = 1'($urandom);
      bus.id_wmem = 1'($urandom); bus.id_aluc = 4'($urandom);
      bus.id_aluimm = 1'($urandom); bus.id_imm = $urandom;
      bus.id_rn = RW'($urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.ex_wreg = 1'($urandom); bus.ex_m2reg = 1'($urandom);
      bus.ex_rn = RW'($urandom_range(0, 3)); bus.ex_alu = $urandom;
      bus.mm_wreg = 1'($urandom); bus.mm_m2reg = 1'($urandom);
      bus.mm_rn = RW'($urandom_range(0, 3));
      bus.mm_alu = $urandom; bus.mm_mdo = $urandom;
      #1;
      xa = m_src(bus.rna); xb = m_src(bus.rnb); xs = m_stall();
      bub = xs || bus.flush;
      ea = m_val(xa, bus.qa); eb = m_val(xb, bus.qb);
      xw = bus.id_wreg && !bub; xm = bus.id_m2reg && !bub;
      xs_m = bus.id_wmem && !bub; xai = bus.id_aluimm;
      xal = bus.id_aluc; ximm = bus.id_imm; xrn = bus.id_rn;
      chk("rnd_fwda", {30'b0, bus.fwda}, {30'b0, xa});
      chk("rnd_fwdb", {30'b0, bus.fwdb}, {30'b0, xb});
      chk("rnd_stall", {31'b0, bus.stall}, {31'b0, xs});
      @(posedge clk); #1;
      chk("rnd_e_a", bus.e_a, ea);
      chk("rnd_e_b", bus.e_b, eb);
      chk("rnd_ctl", {27'b0, bus.e_wreg, bus.e_m2reg, bus.e_wmem,
                      bus.e_aluimm, 1'b0},
                     {27'b0, xw, xm, xs_m, xai, 1'b0});
      chk("rnd_e_aluc", {28'b0, bus.e_aluc}, {28'b0, xal});
      chk("rnd_e_imm", bus.e_imm, ximm);
      chk("rnd_e_rn", {27'b0, bus.e_rn}, {27'b0, xrn});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
